bit_serializer: RTL and testbench

Parallel-in, serial-out bit source that feeds the serial input `j` of the team's Mealy sequence detectors, one bit per clock.
- Accepts a word plus a bit count through a valid/ready load handshake.
- Emits the low `len` bits MSB-first on `j`, qualified by `j_valid`.
- Pulses `done` after the last bit.
- Supports gapless back-to-back words, so detector patterns can span word boundaries.

---
 rtl/bit_serializer_pkg.sv | 18 +
 rtl/bit_serializer_if.sv | 28 ++
 rtl/bit_serializer.sv | 71 +++++++
 tb/tb_bit_serializer.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/bit_serializer_pkg.sv
// Shared definitions for serial bit sources and the sequence detectors they feed.
package bit_serializer_pkg;

  // Serializer FSM states; binary 1-bit encoding.
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  // Effective bit count: 0 or anything above the word width means "whole word".
  function automatic int eff_len(input int len, input int width);
    if (len == 0 || len > width) begin
      return width;
    end
    return len;
  endfunction

endpackage

// File: rtl/bit_serializer_if.sv
// Load handshake plus serial output bundle of the bit serializer.
// Handshake: a load transfers on a rising edge where load_valid && load_ready;
// data_in/len must be stable while load_valid is high and are only sampled at
// that edge. j is meaningful only while j_valid is high.
interface bit_serializer_if #(
  parameter int WIDTH = 8,
  parameter int CNTW  = 4
) ();
  logic [WIDTH-1:0] data_in;
  logic [CNTW-1:0]  len;
  logic             load_valid;
  logic             load_ready;
  logic             j;
  logic             j_valid;
  logic             done;

  // Producer of words / consumer of the bit stream.
  modport master (
    output data_in, len, load_valid,
    input  load_ready, j, j_valid, done
  );

  // The serializer itself.
  modport slave (
    input  data_in, len, load_valid,
    output load_ready, j, j_valid, done
  );
endinterface

// File: rtl/bit_serializer.sv
// Parallel-in, serial-out bit source: sends the low len bits MSB-first, one per
// clock, with gapless back-to-back loads and a done pulse after each word.
module bit_serializer
  import bit_serializer_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNTW  = 4
) (
  input  logic   clk,
  input  logic   rst,
  bit_serializer_if.slave bus,
  output state_t state_o
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;
  logic             done_q, done_d;

  logic             last_bit;
  logic             accept;
  logic [CNTW-1:0]  n_eff;

  // The last-bit cycle is the only SHIFT cycle that may take the next word.
  assign last_bit = (state_q == ST_SHIFT) && (cnt_q == CNTW'(1));
  assign accept   = bus.load_valid && bus.load_ready;
  assign n_eff    = CNTW'(eff_len(int'(bus.len), WIDTH));

  assign bus.load_ready = (state_q == ST_IDLE) || last_bit;
  assign bus.j          = (state_q == ST_SHIFT) && shreg_q[WIDTH-1];
  assign bus.j_valid    = (state_q == ST_SHIFT);
  assign bus.done       = done_q;
  assign state_o        = state_q;

  // Next-state: load aligns bit N-1 to the MSB; otherwise shift and count down.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    done_d  = last_bit;
    if (accept) begin
      state_d = ST_SHIFT;
      shreg_d = bus.data_in << (WIDTH - int'(n_eff));
      cnt_d   = n_eff;
    end else if (state_q == ST_SHIFT) begin
      shreg_d = shreg_q << 1;
      if (cnt_q >= CNTW'(1)) begin
        cnt_d = cnt_q - CNTW'(1);
      end
      if (cnt_q <= CNTW'(1)) begin
        state_d = ST_IDLE;
      end
    end
  end

  // State registers; reset drops any word in flight without a done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_bit_serializer.sv
// Directed bench for bit_serializer with hand-computed bit streams.
module tb_bit_serializer;
  import bit_serializer_pkg::*;

  localparam int WIDTH = 8;
  localparam int CNTW  = 4;

  logic   clk;
  logic   rst;
  state_t state_o;
  int     n_cmp;
  int     n_bad;

  bit_serializer_if #(.WIDTH(WIDTH), .CNTW(CNTW)) bus ();

  bit_serializer #(.WIDTH(WIDTH), .CNTW(CNTW)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .state_o (state_o)
  );

  // Clock and reset.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Check the four outputs of the current cycle.
  task automatic chk_out(input string tag, input logic ej, input logic ejv,
                         input logic elr, input logic edn);
    check({tag, ".j"},          32'(bus.j),          32'(ej));
    check({tag, ".j_valid"},    32'(bus.j_valid),    32'(ejv));
    check({tag, ".load_ready"}, 32'(bus.load_ready), 32'(elr));
    check({tag, ".done"},       32'(bus.done),       32'(edn));
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a load; the next edge accepts it (caller guarantees ready).
  task automatic drive_load(input logic [WIDTH-1:0] d, input logic [CNTW-1:0] l);
    bus.data_in    = d;
    bus.len        = l;
    bus.load_valid = 1'b1;
  endtask

  task automatic idle_load();
    bus.load_valid = 1'b0;
    bus.data_in    = '0;
    bus.len        = '0;
  endtask

  // Send one word from IDLE and check its bit stream plus done timing.
  task automatic send_word(input string tag, input logic [WIDTH-1:0] d,
                           input logic [CNTW-1:0] l, input logic [WIDTH-1:0] exp_bits,
                           input int n);
    drive_load(d, l);
    step();
    idle_load();
    for (int i = n - 1; i >= 0; i--) begin
      chk_out(tag, exp_bits[i], 1'b1, (i == 0), 1'b0);
      step();
    end
    chk_out({tag, ".end"}, 1'b0, 1'b0, 1'b1, 1'b1);
    step();
    chk_out({tag, ".after"}, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    idle_load();
    rst = 1'b1;
    #1;
    chk_out("rst", 1'b0, 1'b0, 1'b1, 1'b0);
    check("rst.state", 32'(state_o), 32'(ST_IDLE));
    step();
    step();
    rst = 1'b0;
    step();
    chk_out("idle", 1'b0, 1'b0, 1'b1, 1'b0);

    // 1. Reset mid-word after 3 of 8 bits.
    drive_load(8'hC3, 4'd8);
    step();
    idle_load();
    chk_out("mid.b7", 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    chk_out("mid.b6", 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    chk_out("mid.b5", 1'b0, 1'b1, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    chk_out("mid.rst", 1'b0, 1'b0, 1'b1, 1'b0);
    check("mid.state", 32'(state_o), 32'(ST_IDLE));
    #2;
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      check("mid.nodone", 32'(bus.done), 32'(0));
    end
    send_word("restart", 8'h81, 4'd8, 8'h81, 8);

    // 2. Single word, len=5 -> 1,0,0,1,0.
    send_word("single", 8'b0001_0010, 4'd5, 8'b0001_0010, 5);

    // 3. Length clamp.
    send_word("len0", 8'hA5, 4'd0, 8'hA5, 8);
    send_word("len12", 8'hA5, 4'd12, 8'hA5, 8);

    // 4. Back-to-back A=101 then B=10 with load_valid held.
    drive_load(8'b101, 4'd3);
    step();
    drive_load(8'b10, 4'd2);
    chk_out("b2b.1", 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    chk_out("b2b.2", 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    chk_out("b2b.3", 1'b1, 1'b1, 1'b1, 1'b0);
    step();
    idle_load();
    chk_out("b2b.4", 1'b1, 1'b1, 1'b0, 1'b1);
    step();
    chk_out("b2b.5", 1'b0, 1'b1, 1'b1, 1'b0);
    step();
    chk_out("b2b.6", 1'b0, 1'b0, 1'b1, 1'b1);
    step();
    chk_out("b2b.7", 1'b0, 1'b0, 1'b1, 1'b0);

    // 5. Held request: only the value at the accepting edge is taken.
    drive_load(8'h0B, 4'd4);
    step();
    drive_load(8'h01, 4'd2);
    chk_out("held.1", 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    chk_out("held.2", 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    drive_load(8'h02, 4'd2);
    chk_out("held.3", 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    chk_out("held.4", 1'b1, 1'b1, 1'b1, 1'b0);
    step();
    idle_load();
    chk_out("held.5", 1'b1, 1'b1, 1'b0, 1'b1);
    step();
    chk_out("held.6", 1'b0, 1'b1, 1'b1, 1'b0);
    step();
    chk_out("held.7", 1'b0, 1'b0, 1'b1, 1'b1);

    // 6. Single-bit word.
    step();
    send_word("len1", 8'h01, 4'd1, 8'h01, 1);

    // Data changes while IDLE with no request have no effect.
    bus.data_in = 8'hFF;
    bus.len     = 4'd3;
    step();
    chk_out("noreq", 1'b0, 1'b0, 1'b1, 1'b0);
    check("noreq.state", 32'(state_o), 32'(ST_IDLE));
    idle_load();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
